// File: rtl/fast_pkg.sv
// Shared types for the FAST corner pipeline: coordinate/pixel widths, the corner record
// and the collector FSM state encoding.
package fast_pkg;

  localparam int unsigned COORD_W = 9;
  localparam int unsigned PIX_W   = 8;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [PIX_W-1:0]   score;
  } corner_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    FLUSH,
    DRAIN
  } state_t;

endpackage

// File: rtl/corner_fifo.sv
// Synchronous first-word-fall-through FIFO of corner records with an occupancy output.
// Depth must be a power of two so the pointers wrap naturally.
module corner_fifo
  import fast_pkg::*;
#(
  parameter int unsigned Depth = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  corner_t                  data_i,
  input  logic                     pop_i,
  output corner_t                  data_o,
  output logic                     valid_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam logic [AW:0] DepthC = (AW + 1)'(Depth);

  corner_t       mem_q [Depth];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign valid_o = (count_q != '0);
  assign count_o = count_q;
  assign do_pop  = pop_i && valid_o;
  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign do_push = push_i && ((count_q != DepthC) || do_pop);
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/fast_corner_collector.sv
// Raster-scans the SRAM4 score map, queues every pixel scoring above the threshold and
// hands the corners to the orientation stage; stops early once the corner budget is spent.
module fast_corner_collector
  import fast_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned MAX_CORNERS = 256,
  parameter int unsigned CNT_W       = 9
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               start,
  input  logic [COORD_W-1:0] max_x,
  input  logic [COORD_W-1:0] max_y,
  input  logic [PIX_W-1:0]   threshold,
  output logic               read_SRAM4,
  output logic [COORD_W-1:0] x_addr4,
  output logic [COORD_W-1:0] y_addr4,
  input  logic [PIX_W-1:0]   SRAM4_in,
  output logic               corner_valid,
  input  logic               corner_ready,
  output logic [COORD_W-1:0] corner_x,
  output logic [COORD_W-1:0] corner_y,
  output logic [PIX_W-1:0]   corner_score,
  output logic               busy,
  output logic               done,
  output logic               limit_hit,
  output logic [CNT_W-1:0]   corner_count
);

  state_t               state_q;
  logic [COORD_W-1:0]   x_q, y_q, max_x_q, max_y_q;
  logic [COORD_W-1:0]   rd_x_q, rd_y_q;
  logic                 rd_valid_q;
  logic [PIX_W-1:0]     thr_q;
  logic [CNT_W-1:0]     count_q;
  logic                 limit_q, busy_q, done_q;
  logic                 stall, read, push, pop;
  logic [$clog2(FIFO_DEPTH):0] occ;
  corner_t              head, in_corner;

  // The in-flight read is counted as if already pushed, so neither the FIFO nor the
  // budget can be overrun by data still on its way back from SRAM4.
  always_comb begin
    stall = ((32'(occ) + 32'(rd_valid_q)) >= FIFO_DEPTH) ||
            ((32'(count_q) + 32'(rd_valid_q)) >= MAX_CORNERS);
    read  = (state_q == SCAN) && !stall;
    push  = rd_valid_q && (SRAM4_in > thr_q) && (32'(count_q) < MAX_CORNERS);
    pop   = corner_valid && corner_ready;
    in_corner = '{x: rd_x_q, y: rd_y_q, score: SRAM4_in};
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_valid_q <= 1'b0;
      rd_x_q     <= '0;
      rd_y_q     <= '0;
    end else begin
      rd_valid_q <= read;
      if (read) begin
        rd_x_q <= x_q;
        rd_y_q <= y_q;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      max_x_q <= '0;
      max_y_q <= '0;
      thr_q   <= '0;
      count_q <= '0;
      limit_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      if (push) begin
        count_q <= count_q + CNT_W'(1);
        if ((32'(count_q) + 32'd1) == MAX_CORNERS) limit_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            thr_q   <= threshold;
            max_x_q <= max_x;
            max_y_q <= max_y;
            x_q     <= '0;
            y_q     <= '0;
            count_q <= '0;
            limit_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (32'(count_q) >= MAX_CORNERS) begin
            state_q <= FLUSH;
          end else if (read) begin
            if (x_q == max_x_q) begin
              x_q <= '0;
              if (y_q == max_y_q) state_q <= FLUSH;
              else                y_q     <= y_q + 1'b1;
            end else begin
              x_q <= x_q + 1'b1;
            end
          end
        end
        FLUSH: state_q <= DRAIN;
        DRAIN: begin
          // done is raised for the last busy cycle; both fall together.
          if (done_q) begin
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (occ == '0) begin
            done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  corner_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (n_rst),
    .push_i  (push),
    .data_i  (in_corner),
    .pop_i   (pop),
    .data_o  (head),
    .valid_o (corner_valid),
    .count_o (occ)
  );

  assign read_SRAM4   = read;
  assign x_addr4      = x_q;
  assign y_addr4      = y_q;
  assign corner_x     = head.x;
  assign corner_y     = head.y;
  assign corner_score = head.score;
  assign busy         = busy_q;
  assign done         = done_q;
  assign limit_hit    = limit_q;
  assign corner_count = count_q;

endmodule

// File: tb/tb_fast_corner_collector.sv
// Directed bench for fast_corner_collector: a 4-deep instance for ordering/stall/reset
// and a 3-corner-budget instance for early termination, both fed from one score image.
module tb_fast_corner_collector;

  logic       clk, n_rst;
  logic [8:0] max_x, max_y;
  logic [7:0] threshold;

  logic       start_a, ready_a, read_a, valid_a, busy_a, done_a, limit_a;
  logic [8:0] xa, ya, cxa, cya, count_a;
  logic [7:0] sram_a, csa;

  logic       start_b, ready_b, read_b, valid_b, busy_b, done_b, limit_b;
  logic [8:0] xb, yb, cxb, cyb, count_b;
  logic [7:0] sram_b, csb;

  logic [7:0]  img [0:63];
  logic [25:0] exp_a [$];
  logic [25:0] exp_b [$];

  int checks, failures;
  int rd_cnt_a, rd_cnt_b, done_cnt_a, done_cnt_b;
  int rd_base, done_base;

  fast_corner_collector #(.FIFO_DEPTH(4), .MAX_CORNERS(256), .CNT_W(9)) dut_a (
    .clk(clk), .n_rst(n_rst), .start(start_a), .max_x(max_x), .max_y(max_y),
    .threshold(threshold), .read_SRAM4(read_a), .x_addr4(xa), .y_addr4(ya),
    .SRAM4_in(sram_a), .corner_valid(valid_a), .corner_ready(ready_a), .corner_x(cxa),
    .corner_y(cya), .corner_score(csa), .busy(busy_a), .done(done_a), .limit_hit(limit_a),
    .corner_count(count_a)
  );

  fast_corner_collector #(.FIFO_DEPTH(8), .MAX_CORNERS(3), .CNT_W(9)) dut_b (
    .clk(clk), .n_rst(n_rst), .start(start_b), .max_x(max_x), .max_y(max_y),
    .threshold(threshold), .read_SRAM4(read_b), .x_addr4(xb), .y_addr4(yb),
    .SRAM4_in(sram_b), .corner_valid(valid_b), .corner_ready(ready_b), .corner_x(cxb),
    .corner_y(cyb), .corner_score(csb), .busy(busy_b), .done(done_b), .limit_hit(limit_b),
    .corner_count(count_b)
  );

  always #5 clk = ~clk;

  // SRAM4 models: data valid one cycle after the read strobe.
  always @(posedge clk) begin
    if (read_a && (int'(ya) * 8 + int'(xa)) < 64) sram_a <= img[int'(ya) * 8 + int'(xa)];
    if (read_b && (int'(yb) * 8 + int'(xb)) < 64) sram_b <= img[int'(yb) * 8 + int'(xb)];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit use_b, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      seen = use_b ? done_b : done_a;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  task automatic build_exp(input bit use_b, input int mx, input int my, input int thr,
                           input int lim);
    int n = 0;
    for (int y = 0; y <= my; y++)
      for (int x = 0; x <= mx; x++)
        if (int'(img[y * 8 + x]) > thr && n < lim) begin
          n++;
          if (use_b) exp_b.push_back({9'(x), 9'(y), img[y * 8 + x]});
          else       exp_a.push_back({9'(x), 9'(y), img[y * 8 + x]});
        end
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 64; i++) img[i] = v;
  endtask

  task automatic pulse_a();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  initial begin
    clk = 1'b0; n_rst = 1'b0;
    start_a = 1'b0; ready_a = 1'b1; start_b = 1'b0; ready_b = 1'b1;
    max_x = '0; max_y = '0; threshold = '0;
    checks = 0; failures = 0;
    rd_cnt_a = 0; rd_cnt_b = 0; done_cnt_a = 0; done_cnt_b = 0;
    fill(8'd0);

    fork
      forever begin
        @(negedge clk);
        if (read_a) rd_cnt_a++;
        if (read_b) rd_cnt_b++;
        if (valid_a && ready_a)
          check("a_order", 32'({cxa, cya, csa}),
                32'(exp_a.size() != 0 ? exp_a.pop_front() : 26'h3ffffff));
        else if (!valid_a)
          check("a_empty_zero", 32'({cxa, cya, csa}), 32'd0);
        if (valid_b && ready_b)
          check("b_order", 32'({cxb, cyb, csb}),
                32'(exp_b.size() != 0 ? exp_b.pop_front() : 26'h3ffffff));
        if (done_a) begin
          done_cnt_a++;
          check("a_done_fifo_empty", 32'(valid_a), 32'd0);
        end
        if (done_b) done_cnt_b++;
      end
    join_none

    // Reset state
    repeat (3) tick();
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_valid", 32'(valid_a), 32'd0);
    check("rst_read", 32'(read_a), 32'd0);
    check("rst_addr", 32'({xa, ya}), 32'd0);
    check("rst_count", 32'(count_a), 32'd0);
    check("rst_limit", 32'(limit_a), 32'd0);
    check("rst_busy_b", 32'(busy_b), 32'd0);
    n_rst = 1'b1;
    tick();

    // 4x2 frame, two corners, consumer always ready
    fill(8'd0);
    for (int y = 0; y < 2; y++) for (int x = 0; x < 4; x++) img[y * 8 + x] = 8'(y * 4 + x);
    img[0] = 8'd11; img[8 + 2] = 8'd50;
    max_x = 9'd3; max_y = 9'd1; threshold = 8'd10; ready_a = 1'b1;
    build_exp(1'b0, 3, 1, 10, 1000);
    rd_base = rd_cnt_a; done_base = done_cnt_a;
    pulse_a();
    check("t1_busy_after_start", 32'(busy_a), 32'd1);
    wait_done(1'b0, "t1_done_seen");
    check("t1_busy_with_done", 32'(busy_a), 32'd1);
    @(negedge clk);
    check("t1_done_one_cycle", 32'(done_a), 32'd0);
    check("t1_busy_fell", 32'(busy_a), 32'd0);
    repeat (3) tick();
    check("t1_count", 32'(count_a), 32'd2);
    check("t1_reads", 32'(rd_cnt_a - rd_base), 32'd8);
    check("t1_done_pulses", 32'(done_cnt_a - done_base), 32'd1);
    check("t1_drained", 32'(exp_a.size()), 32'd0);
    check("t1_limit", 32'(limit_a), 32'd0);

    // Backpressure: 4-deep FIFO stalls the scan, then drains in raster order
    fill(8'd200);
    ready_a = 1'b0;
    build_exp(1'b0, 3, 1, 10, 1000);
    rd_base = rd_cnt_a; done_base = done_cnt_a;
    pulse_a();
    repeat (12) tick();
    check("t2_stall_reads", 32'(rd_cnt_a - rd_base), 32'd4);
    check("t2_stall_no_read", 32'(read_a), 32'd0);
    check("t2_stall_addr", 32'({xa, ya}), 32'({9'd0, 9'd1}));
    check("t2_stall_head", 32'({cxa, cya, csa}), 32'({9'd0, 9'd0, 8'd200}));
    check("t2_no_early_done", 32'(done_cnt_a - done_base), 32'd0);
    ready_a = 1'b1;
    wait_done(1'b0, "t2_done_seen");
    repeat (3) tick();
    check("t2_reads", 32'(rd_cnt_a - rd_base), 32'd8);
    check("t2_count", 32'(count_a), 32'd8);
    check("t2_drained", 32'(exp_a.size()), 32'd0);

    // Threshold boundary: equal is rejected
    fill(8'd0);
    img[0] = 8'd99; img[1] = 8'd100; img[2] = 8'd101;
    max_x = 9'd2; max_y = 9'd0; threshold = 8'd100;
    build_exp(1'b0, 2, 0, 100, 1000);
    pulse_a();
    wait_done(1'b0, "t3_done_seen");
    repeat (3) tick();
    check("t3_count", 32'(count_a), 32'd1);
    check("t3_drained", 32'(exp_a.size()), 32'd0);

    // Budget of 3 on a 4x4 frame of 255s
    fill(8'd255);
    max_x = 9'd3; max_y = 9'd3; threshold = 8'd0;
    build_exp(1'b1, 3, 3, 0, 3);
    rd_base = rd_cnt_b; done_base = done_cnt_b;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    wait_done(1'b1, "t4_done_seen");
    repeat (3) tick();
    check("t4_reads", 32'(rd_cnt_b - rd_base), 32'd3);
    check("t4_count", 32'(count_b), 32'd3);
    check("t4_limit", 32'(limit_b), 32'd1);
    check("t4_done_pulses", 32'(done_cnt_b - done_base), 32'd1);
    check("t4_drained", 32'(exp_b.size()), 32'd0);

    // Reset mid-scan with two entries queued
    fill(8'd200);
    max_x = 9'd3; max_y = 9'd1; threshold = 8'd10; ready_a = 1'b0;
    build_exp(1'b0, 3, 1, 10, 1000);
    done_base = done_cnt_a;
    pulse_a();
    repeat (3) tick();
    check("t5_pre_valid", 32'(valid_a), 32'd1);
    check("t5_pre_busy", 32'(busy_a), 32'd1);
    n_rst = 1'b0;
    exp_a.delete();
    #1;
    check("t5_rst_valid", 32'(valid_a), 32'd0);
    check("t5_rst_head", 32'({cxa, cya, csa}), 32'd0);
    check("t5_rst_busy", 32'(busy_a), 32'd0);
    check("t5_rst_read", 32'(read_a), 32'd0);
    check("t5_rst_addr", 32'({xa, ya}), 32'd0);
    check("t5_rst_count", 32'(count_a), 32'd0);
    repeat (3) tick();
    n_rst = 1'b1;
    ready_a = 1'b1;
    repeat (3) tick();
    check("t5_no_done", 32'(done_cnt_a - done_base), 32'd0);

    // Single-pixel frame, start re-pulsed while busy
    fill(8'd0);
    img[0] = 8'd255;
    max_x = 9'd0; max_y = 9'd0; threshold = 8'd0;
    build_exp(1'b0, 0, 0, 0, 1000);
    rd_base = rd_cnt_a; done_base = done_cnt_a;
    start_a = 1'b1;
    tick();
    check("t6_first_read", 32'(read_a), 32'd1);
    check("t6_first_addr", 32'({xa, ya}), 32'd0);
    tick();
    start_a = 1'b0;
    wait_done(1'b0, "t6_done_seen");
    repeat (6) tick();
    check("t6_reads", 32'(rd_cnt_a - rd_base), 32'd1);
    check("t6_count", 32'(count_a), 32'd1);
    check("t6_done_pulses", 32'(done_cnt_a - done_base), 32'd1);
    check("t6_idle", 32'(busy_a), 32'd0);
    check("t6_drained", 32'(exp_a.size()), 32'd0);

    // threshold=255 admits nothing
    threshold = 8'd255;
    pulse_a();
    wait_done(1'b0, "t7_done_seen");
    repeat (3) tick();
    check("t7_count", 32'(count_a), 32'd0);
    check("t7_limit_cleared_b_untouched", 32'(limit_a), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
